// File: rtl/max_pool_2x2_pkg.sv
// Shared definitions for the convolution / pooling pipeline: feature-map
// geometry, sample width and the pooling FSM state encoding.
package max_pool_2x2_pkg;

    localparam int POOL_DIM = 5;
    localparam int POOL_DW  = 36;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_POOL = 2'd2
    } pool_state_e;

endpackage

// File: rtl/max_pool_2x2_max4.sv
// Combinational unsigned maximum of four DW-bit samples.
module max_pool_2x2_max4 #(
    parameter int DW = 36
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] y
);

    logic [DW-1:0] ab_s;
    logic [DW-1:0] cd_s;

    // Two-level compare tree; ties pick either operand, the value is identical.
    always_comb begin
        ab_s = a;
        cd_s = c;
        y    = '0;
        if (b > a) begin
            ab_s = b;
        end else begin
            ab_s = a;
        end
        if (d > c) begin
            cd_s = d;
        end else begin
            cd_s = c;
        end
        if (cd_s > ab_s) begin
            y = cd_s;
        end else begin
            y = ab_s;
        end
    end

endmodule

// File: rtl/max_pool_2x2.sv
// Stride-1 2x2 max pool over a DIM x DIM raster-order feature map, one result
// per accepted sample with r>=1 and c>=1, registered one cycle later.
module max_pool_2x2
    import max_pool_2x2_pkg::*;
#(
    parameter int DIM = POOL_DIM,
    parameter int DW  = POOL_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] In_OFM,
    output logic          out_valid,
    output logic [DW-1:0] Out_Pool,
    output logic          out_last
);

    localparam int            CW       = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DIM - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    pool_state_e   state_r;
    pool_state_e   state_nxt_s;
    logic [CW-1:0] col_r;
    logic [CW-1:0] row_r;
    logic [CW-1:0] col_nxt_s;
    logic [CW-1:0] row_nxt_s;
    logic          col_end_s;
    logic          frame_end_s;
    logic          emit_s;

    logic [DW-1:0] row_buf_r [DIM];
    logic [DW-1:0] left_r;
    logic [DW-1:0] diag_r;
    logic [DW-1:0] above_s;
    logic [DW-1:0] max_s;

    // Previous row's sample in the current column, read before it is overwritten.
    assign above_s = row_buf_r[col_r];

    // Next-state, counter advance and result-emit decode.
    always_comb begin
        state_nxt_s = state_r;
        col_nxt_s   = col_r;
        row_nxt_s   = row_r;
        emit_s      = 1'b0;
        col_end_s   = (col_r == LAST_IDX);
        frame_end_s = col_end_s && (row_r == LAST_IDX);
        if (in_valid) begin
            if (col_end_s) begin
                col_nxt_s = '0;
                if (frame_end_s) begin
                    row_nxt_s = '0;
                end else begin
                    row_nxt_s = row_r + ONE;
                end
            end else begin
                col_nxt_s = col_r + ONE;
                row_nxt_s = row_r;
            end
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_FILL;
                end
                ST_FILL: begin
                    if (col_end_s) begin
                        state_nxt_s = ST_POOL;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end
                ST_POOL: begin
                    emit_s = (col_r != '0);
                    if (frame_end_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_POOL;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    col_nxt_s   = '0;
                    row_nxt_s   = '0;
                end
            endcase
        end else begin
            emit_s = 1'b0;
        end
    end

    // FSM state and raster position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            col_r   <= '0;
            row_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            col_r   <= col_nxt_s;
            row_r   <= row_nxt_s;
        end
    end

    // Window storage; never read before being written within a frame, so unreset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            row_buf_r[col_r] <= In_OFM;
            left_r           <= In_OFM;
            diag_r           <= above_s;
        end
    end

    max_pool_2x2_max4 #(
        .DW(DW)
    ) u_max4 (
        .a(diag_r),
        .b(above_s),
        .c(left_r),
        .d(In_OFM),
        .y(max_s)
    );

    // Registered result; Out_Pool holds its value whenever no result is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            Out_Pool  <= '0;
        end else begin
            out_valid <= emit_s;
            out_last  <= emit_s && frame_end_s;
            if (emit_s) begin
                Out_Pool <= max_s;
            end
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2: a 2D image model computes each expected
// window maximum as samples are driven; outputs are checked one cycle later.
module tb_max_pool_2x2;

    localparam int DIM = 5;
    localparam int DW  = 36;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] In_OFM;
    logic          out_valid;
    logic [DW-1:0] Out_Pool;
    logic          out_last;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW:0]   exp_q [$];
    logic [DW-1:0] img [DIM][DIM];
    int            pr = 0;
    int            pc = 0;
    logic          want_v = 1'b0;
    logic [DW-1:0] last_pool = '0;
    int            ramp_ref [16] = '{6, 7, 8, 9, 11, 12, 13, 14, 16, 17, 18, 19, 21, 22, 23, 24};

    max_pool_2x2 #(.DIM(DIM), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .In_OFM   (In_OFM),
        .out_valid(out_valid),
        .Out_Pool (Out_Pool),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    // Drive one cycle, update the image model, push the expected result if any.
    task automatic drive(input logic v, input logic [DW-1:0] d);
        logic [DW-1:0] m;
        logic          lst;
        @(negedge clk);
        in_valid = v;
        In_OFM   = d;
        want_v   = 1'b0;
        if (v) begin
            img[pr][pc] = d;
            if (pr > 0 && pc > 0) begin
                m = img[pr-1][pc-1];
                if (img[pr-1][pc] > m) m = img[pr-1][pc];
                if (img[pr][pc-1] > m) m = img[pr][pc-1];
                if (img[pr][pc] > m)   m = img[pr][pc];
                lst = (pr == DIM-1) && (pc == DIM-1);
                exp_q.push_back({lst, m});
                want_v = 1'b1;
            end
            if (pc == DIM-1) begin
                pc = 0;
                pr = (pr == DIM-1) ? 0 : pr + 1;
            end else begin
                pc = pc + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] junk();
        return DW'({$urandom, $urandom});
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        In_OFM   = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++;
        if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        n_cmp++;
        if (Out_Pool !== '0) begin n_bad++; $display("FAIL reset_out_pool got=%0h exp=0", Out_Pool); end
        @(negedge clk);
        rst_n     = 1'b1;
        last_pool = '0;
    endtask

    task automatic test_ramp();
        stim_t       s [$];
        stim_t       t;
        logic [DW:0] e;
        int          k = 0;
        for (int i = 0; i < 25; i++) begin t.v = 1'b1; t.d = DW'(i); s.push_back(t); end
        t.v = 1'b0; t.d = junk(); s.push_back(t);
        foreach (s[i]) begin
            drive(s[i].v, s[i].d);
            n_cmp++;
            if (out_valid !== want_v) begin n_bad++; $display("FAIL ramp_valid cyc=%0d got=%b exp=%b", i, out_valid, want_v); end
            if (want_v) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({out_last, Out_Pool} !== e) begin n_bad++; $display("FAIL ramp_result cyc=%0d got=%b/%0d exp=%b/%0d", i, out_last, Out_Pool, e[DW], e[DW-1:0]); end
                n_cmp++;
                if (Out_Pool !== DW'(ramp_ref[k])) begin n_bad++; $display("FAIL ramp_ref k=%0d got=%0d exp=%0d", k, Out_Pool, ramp_ref[k]); end
                k++;
                last_pool = e[DW-1:0];
            end else begin
                n_cmp++;
                if (out_last !== 1'b0 || Out_Pool !== last_pool) begin n_bad++; $display("FAIL ramp_hold cyc=%0d got=%b/%0d exp=0/%0d", i, out_last, Out_Pool, last_pool); end
            end
        end
        n_cmp++;
        if (k != 16) begin n_bad++; $display("FAIL ramp_count got=%0d exp=16", k); end
    endtask

    task automatic test_descending();
        stim_t       s [$];
        stim_t       t;
        logic [DW:0] e;
        for (int i = 0; i < 25; i++) begin t.v = 1'b1; t.d = DW'(24 - i); s.push_back(t); end
        t.v = 1'b0; t.d = junk(); s.push_back(t);
        foreach (s[i]) begin
            drive(s[i].v, s[i].d);
            n_cmp++;
            if (out_valid !== want_v) begin n_bad++; $display("FAIL desc_valid cyc=%0d got=%b exp=%b", i, out_valid, want_v); end
            if (want_v) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({out_last, Out_Pool} !== e) begin n_bad++; $display("FAIL desc_result cyc=%0d got=%b/%0d exp=%b/%0d", i, out_last, Out_Pool, e[DW], e[DW-1:0]); end
                last_pool = e[DW-1:0];
            end else begin
                n_cmp++;
                if (out_last !== 1'b0 || Out_Pool !== last_pool) begin n_bad++; $display("FAIL desc_hold cyc=%0d got=%b/%0d exp=0/%0d", i, out_last, Out_Pool, last_pool); end
            end
        end
    endtask

    task automatic test_gaps();
        stim_t       s [$];
        stim_t       t;
        logic [DW:0] e;
        int          g;
        for (int i = 0; i < 25; i++) begin
            t.v = 1'b1; t.d = DW'(i); s.push_back(t);
            g = (i == 4 || i == 12) ? 3 : ((i >= 15 && i <= 19) ? 1 : 0);
            for (int j = 0; j < g; j++) begin t.v = 1'b0; t.d = junk(); s.push_back(t); end
        end
        t.v = 1'b0; t.d = junk(); s.push_back(t);
        foreach (s[i]) begin
            drive(s[i].v, s[i].d);
            n_cmp++;
            if (out_valid !== want_v) begin n_bad++; $display("FAIL gap_valid cyc=%0d got=%b exp=%b", i, out_valid, want_v); end
            if (want_v) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({out_last, Out_Pool} !== e) begin n_bad++; $display("FAIL gap_result cyc=%0d got=%b/%0d exp=%b/%0d", i, out_last, Out_Pool, e[DW], e[DW-1:0]); end
                last_pool = e[DW-1:0];
            end else begin
                n_cmp++;
                if (out_last !== 1'b0 || Out_Pool !== last_pool) begin n_bad++; $display("FAIL gap_hold cyc=%0d got=%b/%0d exp=0/%0d", i, out_last, Out_Pool, last_pool); end
            end
        end
    endtask

    task automatic test_impulse();
        stim_t       s [$];
        stim_t       t;
        logic [DW:0] e;
        for (int i = 0; i < 25; i++) begin t.v = 1'b1; t.d = (i == 12) ? '1 : '0; s.push_back(t); end
        t.v = 1'b0; t.d = junk(); s.push_back(t);
        foreach (s[i]) begin
            drive(s[i].v, s[i].d);
            n_cmp++;
            if (out_valid !== want_v) begin n_bad++; $display("FAIL imp_valid cyc=%0d got=%b exp=%b", i, out_valid, want_v); end
            if (want_v) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({out_last, Out_Pool} !== e) begin n_bad++; $display("FAIL imp_result cyc=%0d got=%b/%0h exp=%b/%0h", i, out_last, Out_Pool, e[DW], e[DW-1:0]); end
                last_pool = e[DW-1:0];
            end else begin
                n_cmp++;
                if (out_last !== 1'b0 || Out_Pool !== last_pool) begin n_bad++; $display("FAIL imp_hold cyc=%0d got=%b/%0h exp=0/%0h", i, out_last, Out_Pool, last_pool); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DW:0] e;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, DW'(i));
            n_cmp++;
            if (out_valid !== want_v) begin n_bad++; $display("FAIL midrst_valid cyc=%0d got=%b exp=%b", i, out_valid, want_v); end
            if (want_v) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({out_last, Out_Pool} !== e) begin n_bad++; $display("FAIL midrst_result cyc=%0d got=%b/%0d exp=%b/%0d", i, out_last, Out_Pool, e[DW], e[DW-1:0]); end
                last_pool = e[DW-1:0];
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_last, Out_Pool} !== '0) begin n_bad++; $display("FAIL midrst_async got=%b/%b/%0d exp=0/0/0", out_valid, out_last, Out_Pool); end
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        pr        = 0;
        pc        = 0;
        last_pool = '0;
        exp_q.delete();
        test_ramp();
    endtask

    task automatic test_back_to_back();
        stim_t       s [$];
        stim_t       t;
        logic [DW:0] e;
        int          n_res  = 0;
        int          n_last = 0;
        for (int i = 0; i < 50; i++) begin t.v = 1'b1; t.d = DW'(i % 25); s.push_back(t); end
        t.v = 1'b0; t.d = junk(); s.push_back(t);
        foreach (s[i]) begin
            drive(s[i].v, s[i].d);
            if (out_valid === 1'b1) n_res++;
            if (out_last === 1'b1) n_last++;
            n_cmp++;
            if (out_valid !== want_v) begin n_bad++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, out_valid, want_v); end
            if (want_v) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({out_last, Out_Pool} !== e) begin n_bad++; $display("FAIL b2b_result cyc=%0d got=%b/%0d exp=%b/%0d", i, out_last, Out_Pool, e[DW], e[DW-1:0]); end
                last_pool = e[DW-1:0];
            end else begin
                n_cmp++;
                if (out_last !== 1'b0 || Out_Pool !== last_pool) begin n_bad++; $display("FAIL b2b_hold cyc=%0d got=%b/%0d exp=0/%0d", i, out_last, Out_Pool, last_pool); end
            end
        end
        n_cmp++;
        if (n_res != 32) begin n_bad++; $display("FAIL b2b_count got=%0d exp=32", n_res); end
        n_cmp++;
        if (n_last != 2) begin n_bad++; $display("FAIL b2b_last_pulses got=%0d exp=2", n_last); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_descending();
        test_gaps();
        test_impulse();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
